// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, default frame parameters and
// the parity helper, kept here so the transmitter can reuse them.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;

   localparam int UART_N_DATA          = 8;
   localparam int UART_PARITY_CHECK    = 0;
   localparam int UART_EVEN_ODD_PARITY = 1;
   localparam int UART_M_STOP          = 1;
   localparam int UART_N_TICK          = 16;

   // data_xor is the XOR of all data bits; odd selects odd (1) or even (0) parity.
   function automatic logic parity_mismatch(input logic data_xor, input logic par_bit,
                                            input logic odd);
      return (data_xor ^ par_bit) != odd;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start bit.
module uart_sync2 (
   input  logic i_clk,
   input  logic i_rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: configurable data/parity/stop framing, delivers
// each word through a valid/ready holding register with error flags.
module uart_rx_ovs
   import uart_pkg::*;
#(
   parameter int N_DATA          = UART_N_DATA,
   parameter int PARITY_CHECK    = UART_PARITY_CHECK,
   parameter int EVEN_ODD_PARITY = UART_EVEN_ODD_PARITY,
   parameter int M_STOP          = UART_M_STOP,
   parameter int N_TICK          = UART_N_TICK
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_data,
   input  logic              i_tick,
   output logic [N_DATA-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_parity_err,
   output logic              o_frame_err,
   output logic              o_overrun
);

   localparam int TW = $clog2(N_TICK);
   localparam int BW = $clog2(N_DATA + 1);

   localparam logic [TW-1:0] TICK_MID  = TW'(N_TICK / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(N_TICK - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(N_DATA - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(M_STOP - 1);
   localparam logic          ODD_PAR   = (EVEN_ODD_PARITY != 0);

   rx_state_t         state;
   logic              rx;
   logic [TW-1:0]     tick_cnt;
   logic [BW-1:0]     bit_cnt;
   logic [N_DATA-1:0] shreg;
   logic              par_err;
   logic              frm_err;

   logic              sample;
   logic              frame_done;
   logic              stop_err;
   logic              load;

   uart_sync2 u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .d     (i_data),
      .q     (rx)
   );

   // Once the start bit is centred, every N_TICK-th tick lands mid-bit.
   assign sample     = i_tick && (tick_cnt == TICK_LAST);
   assign frame_done = sample && (state == ST_STOP) && (bit_cnt == STOP_LAST);
   assign stop_err   = frm_err | ~rx;
   assign load       = frame_done && (!o_valid || i_ready);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= ST_IDLE;
         tick_cnt     <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         par_err      <= 1'b0;
         frm_err      <= 1'b0;
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         if (i_tick) begin
            case (state)
               ST_IDLE: begin
                  if (!rx) begin
                     state    <= ST_START;
                     tick_cnt <= '0;
                  end
               end
               ST_START: begin
                  if (tick_cnt == TICK_MID) begin
                     tick_cnt <= '0;
                     bit_cnt  <= '0;
                     state    <= rx ? ST_IDLE : ST_DATA;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               ST_DATA: begin
                  if (sample) begin
                     tick_cnt <= '0;
                     shreg    <= {rx, shreg[N_DATA-1:1]};
                     if (bit_cnt == DATA_LAST) begin
                        bit_cnt <= '0;
                        par_err <= 1'b0;
                        frm_err <= 1'b0;
                        state   <= (PARITY_CHECK != 0) ? ST_PARITY : ST_STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               ST_PARITY: begin
                  if (sample) begin
                     tick_cnt <= '0;
                     par_err  <= parity_mismatch(^shreg, rx, ODD_PAR);
                     state    <= ST_STOP;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               ST_STOP: begin
                  if (sample) begin
                     tick_cnt <= '0;
                     frm_err  <= stop_err;
                     // Leave at mid-stop so the next start edge is caught early.
                     if (bit_cnt == STOP_LAST) begin
                        bit_cnt <= '0;
                        state   <= ST_IDLE;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end

         if (o_valid && i_ready) begin
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
         end
         // A completion overrides the clear above; a blocked one only flags overrun.
         if (frame_done) begin
            if (load) begin
               o_data       <= shreg;
               o_parity_err <= par_err;
               o_frame_err  <= stop_err;
               o_valid      <= 1'b1;
            end else begin
               o_overrun    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: a default 8N1 instance and an 8E1 instance,
// words checked against a scoreboard queue as they are accepted.
module tb_uart_rx_ovs;
   import uart_pkg::*;

   localparam int NT = 16;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       tick   = 1'b1;
   logic       rx0    = 1'b1;
   logic       rx1    = 1'b1;
   logic       ready0 = 1'b1;
   logic       ready1 = 1'b1;
   logic [7:0] data0, data1;
   logic       valid0, valid1, pe0, pe1, fe0, fe1, ov0, ov1;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   uart_rx_ovs dut0 (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_data       (rx0),
      .i_tick       (tick),
      .o_data       (data0),
      .o_valid      (valid0),
      .i_ready      (ready0),
      .o_parity_err (pe0),
      .o_frame_err  (fe0),
      .o_overrun    (ov0)
   );

   uart_rx_ovs #(.PARITY_CHECK(1), .EVEN_ODD_PARITY(0)) dut1 (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_data       (rx1),
      .i_tick       (tick),
      .o_data       (data1),
      .o_valid      (valid1),
      .i_ready      (ready1),
      .o_parity_err (pe1),
      .o_frame_err  (fe1),
      .o_overrun    (ov1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // bits[0] is the start bit; each bit is held for NT ticks (tick tied high).
   task automatic send(input int which, input logic [15:0] bits, input int nb);
      for (int i = 0; i < nb; i++) begin
         if (which == 0) rx0 = bits[i];
         else            rx1 = bits[i];
         cyc(NT);
      end
      if (which == 0) rx0 = 1'b1;
      else            rx1 = 1'b1;
      cyc(24);
   endtask

   function automatic logic [15:0] f8n1(input logic [7:0] d, input logic stop);
      return {6'b0, stop, d, 1'b0};
   endfunction

   function automatic logic [15:0] f8p1(input logic [7:0] d, input logic par);
      return {5'b0, 1'b1, par, d, 1'b0};
   endfunction

   always @(negedge clk) begin
      if (!rst && valid0 && ready0) begin
         if (q0.size() == 0) begin
            chk("dut0_spurious_word", 32'(q0.size()), 32'd1);
         end else begin
            e0 = q0.pop_front();
            chk("dut0_data", 32'(data0), 32'(e0.d));
            chk("dut0_parity_err", 32'(pe0), 32'(e0.pe));
            chk("dut0_frame_err", 32'(fe0), 32'(e0.fe));
         end
      end
      if (!rst && valid1 && ready1) begin
         if (q1.size() == 0) begin
            chk("dut1_spurious_word", 32'(q1.size()), 32'd1);
         end else begin
            e1 = q1.pop_front();
            chk("dut1_data", 32'(data1), 32'(e1.d));
            chk("dut1_parity_err", 32'(pe1), 32'(e1.pe));
            chk("dut1_frame_err", 32'(fe1), 32'(e1.fe));
         end
      end
   end

   initial begin
      int w;
      rst = 1'b1;
      cyc(4);
      chk("rst_data", 32'(data0), 32'h0);
      chk("rst_valid", 32'(valid0), 32'h0);
      chk("rst_parity_err", 32'(pe0), 32'h0);
      chk("rst_frame_err", 32'(fe0), 32'h0);
      chk("rst_overrun", 32'(ov0), 32'h0);
      chk("rst_state", 32'(dut0.state), 32'(ST_IDLE));
      rst = 1'b0;
      cyc(4);

      // 8N1 0x03: latency = 2 sync + NT/2 + NT*9 ticks + 1 register = 155 edges.
      q0.push_back('{d: 8'h03, pe: 1'b0, fe: 1'b0});
      fork
         send(0, f8n1(8'h03, 1'b1), 10);
         begin : lat_mon
            int  n;
            bit  seen;
            n    = 0;
            seen = 1'b0;
            while (!seen && n < 400) begin
               @(posedge clk);
               #1;
               n++;
               if (valid0) seen = 1'b1;
            end
            chk("latency_8n1", 32'(n), 32'd155);
            @(posedge clk);
            #1;
            chk("valid_one_cycle", 32'(valid0), 32'h0);
         end
      join

      // Even parity: 0x0C has two ones, so parity bit 1 is an error.
      q1.push_back('{d: 8'h0C, pe: 1'b1, fe: 1'b0});
      send(1, f8p1(8'h0C, 1'b1), 11);
      q1.push_back('{d: 8'h0C, pe: 1'b0, fe: 1'b0});
      send(1, f8p1(8'h0C, 1'b0), 11);

      // Framing error then a clean frame.
      q0.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b1});
      send(0, f8n1(8'hA5, 1'b0), 10);
      q0.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b0});
      send(0, f8n1(8'h5A, 1'b1), 10);

      // Short low glitch is rejected at mid-start.
      rx0 = 1'b0;
      cyc(4);
      rx0 = 1'b1;
      cyc(40);
      chk("glitch_no_valid", 32'(valid0), 32'h0);
      chk("glitch_state_idle", 32'(dut0.state), 32'(ST_IDLE));
      q0.push_back('{d: 8'h20, pe: 1'b0, fe: 1'b0});
      send(0, f8n1(8'h20, 1'b1), 10);

      // Overrun: second word dropped while the first is held.
      ready0 = 1'b0;
      q0.push_back('{d: 8'h03, pe: 1'b0, fe: 1'b0});
      send(0, f8n1(8'h03, 1'b1), 10);
      send(0, f8n1(8'h0C, 1'b1), 10);
      chk("ovr_data_held", 32'(data0), 32'h03);
      chk("ovr_valid_held", 32'(valid0), 32'h1);
      chk("ovr_overrun_set", 32'(ov0), 32'h1);
      ready0 = 1'b1;
      cyc(1);
      ready0 = 1'b0;
      chk("ovr_valid_cleared", 32'(valid0), 32'h0);
      chk("ovr_overrun_cleared", 32'(ov0), 32'h0);
      ready0 = 1'b1;

      // Reset during the data bits of 0x20 aborts the frame.
      rx0 = 1'b0;
      cyc(NT * 4);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      rx0 = 1'b1;
      chk("midrst_state_idle", 32'(dut0.state), 32'(ST_IDLE));
      cyc(200);
      chk("midrst_no_valid", 32'(valid0), 32'h0);
      q0.push_back('{d: 8'h20, pe: 1'b0, fe: 1'b0});
      send(0, f8n1(8'h20, 1'b1), 10);

      w = 0;
      while ((q0.size() != 0 || q1.size() != 0) && w < 500) begin
         cyc(1);
         w++;
      end
      chk("dut0_queue_drained", 32'(q0.size()), 32'd0);
      chk("dut1_queue_drained", 32'(q1.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
